// File: rtl/audio_pkg.sv
// Shared types and constants for the audio volume stage.
// The sample and gain types describe the default 24-bit / 8-bit configuration.
package audio_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int GAIN_WIDTH_DEF = 8;

    typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;
    typedef logic        [GAIN_WIDTH_DEF-1:0] gain_t;

    // Gain is Q1.7, so 128 is unity and the product is rescaled by 7 bits
    localparam gain_t   UNITY_GAIN = 8'd128;
    localparam int      GAIN_FRAC  = 7;
    localparam sample_t SAMPLE_MAX = 24'sh7FFFFF;
    localparam sample_t SAMPLE_MIN = 24'sh800000;

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        IDLE  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/audio_sat_mul.sv
// Combinational Q1.7 gain multiply for one channel: signed product, floor
// shift by the fraction width, then saturation to the sample range.
module audio_sat_mul
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic        [GAIN_WIDTH-1:0] gain,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         clip
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;

    localparam logic signed [PW-1:0] MAX_PW = {{(GAIN_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_PW = {{(GAIN_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] sample_ext_s;
    logic signed [PW-1:0] gain_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shifted_s;

    // Gain is unsigned, so it is zero-extended before the signed multiply
    assign sample_ext_s = {{(GAIN_WIDTH+1){sample_in[DATA_WIDTH-1]}}, sample_in};
    assign gain_ext_s   = {{(DATA_WIDTH+1){1'b0}}, gain};
    assign prod_s       = sample_ext_s * gain_ext_s;
    assign shifted_s    = prod_s >>> GAIN_FRAC;

    // Clamp the rescaled product into the representable sample range
    always_comb begin
        result = shifted_s[DATA_WIDTH-1:0];
        clip   = 1'b0;
        if (shifted_s > MAX_PW) begin
            result = RES_MAX;
            clip   = 1'b1;
        end else if (shifted_s < MIN_PW) begin
            result = RES_MIN;
            clip   = 1'b1;
        end else begin
            result = shifted_s[DATA_WIDTH-1:0];
            clip   = 1'b0;
        end
    end

endmodule

// File: rtl/audio_volume_ramp.sv
// Stereo volume stage between the noise filter and the codec: the applied gain
// walks toward the (possibly muted) target one clamped step per sample strobe.
module audio_volume_ramp
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         read_ready,
    input  logic                         write_ready,
    input  logic signed [DATA_WIDTH-1:0] in_left,
    input  logic signed [DATA_WIDTH-1:0] in_right,
    input  logic        [GAIN_WIDTH-1:0] target_gain,
    input  logic                         mute,
    output logic signed [DATA_WIDTH-1:0] out_left,
    output logic signed [DATA_WIDTH-1:0] out_right,
    output logic        [GAIN_WIDTH-1:0] cur_gain,
    output logic                         ramping,
    output logic                         clip_left,
    output logic                         clip_right
);

    localparam logic [GAIN_WIDTH-1:0] STEP_G    = GAIN_WIDTH'(RAMP_STEP);
    localparam logic [GAIN_WIDTH-1:0] GAIN_ZERO = {GAIN_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    ramp_state_t                  state_q, state_d;
    logic        [GAIN_WIDTH-1:0] cur_gain_q, cur_gain_d;
    logic signed [DATA_WIDTH-1:0] out_left_q, out_left_d;
    logic signed [DATA_WIDTH-1:0] out_right_q, out_right_d;
    logic                         clip_left_q, clip_left_d;
    logic                         clip_right_q, clip_right_d;

    logic                         strobe_s;
    logic        [GAIN_WIDTH-1:0] eff_s;
    logic        [GAIN_WIDTH-1:0] up_gain_s;
    logic        [GAIN_WIDTH-1:0] down_gain_s;
    logic                         go_up_s;
    logic                         go_down_s;
    logic signed [DATA_WIDTH-1:0] mul_left_s, mul_right_s;
    logic                         mul_clip_left_s, mul_clip_right_s;

    // After a step, the state keeps moving unless the gain landed on the target
    function automatic ramp_state_t settle(input logic [GAIN_WIDTH-1:0] gain,
                                           input logic [GAIN_WIDTH-1:0] eff,
                                           input ramp_state_t           moving);
        ramp_state_t st;
        if (gain != eff) begin
            st = moving;
        end else if (eff == GAIN_ZERO) begin
            st = MUTED;
        end else begin
            st = IDLE;
        end
        return st;
    endfunction

    assign strobe_s = read_ready & write_ready;
    assign eff_s    = mute ? GAIN_ZERO : target_gain;

    // Steps clamp at the target, so the gain can neither overshoot nor wrap
    assign up_gain_s   = ((eff_s - cur_gain_q) <= STEP_G) ? eff_s : (cur_gain_q + STEP_G);
    assign down_gain_s = ((cur_gain_q - eff_s) <= STEP_G) ? eff_s : (cur_gain_q - STEP_G);

    audio_sat_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mul_left (
        .sample_in (in_left),
        .gain      (cur_gain_q),
        .result    (mul_left_s),
        .clip      (mul_clip_left_s)
    );

    audio_sat_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mul_right (
        .sample_in (in_right),
        .gain      (cur_gain_q),
        .result    (mul_right_s),
        .clip      (mul_clip_right_s)
    );

    // Ramp FSM: direction is re-evaluated against the effective target every strobe
    always_comb begin
        state_d    = state_q;
        cur_gain_d = cur_gain_q;
        go_up_s    = 1'b0;
        go_down_s  = 1'b0;
        case (state_q)
            UP: begin
                if (eff_s < cur_gain_q) begin
                    go_down_s = 1'b1;
                end else begin
                    go_up_s = 1'b1;
                end
            end
            DOWN: begin
                if (eff_s > cur_gain_q) begin
                    go_up_s = 1'b1;
                end else begin
                    go_down_s = 1'b1;
                end
            end
            MUTED, IDLE: begin
                if (eff_s > cur_gain_q) begin
                    go_up_s = 1'b1;
                end else if (eff_s < cur_gain_q) begin
                    go_down_s = 1'b1;
                end else begin
                    go_up_s = 1'b0;
                end
            end
            default: begin
                go_down_s = 1'b1;
            end
        endcase
        if (!strobe_s) begin
            state_d    = state_q;
            cur_gain_d = cur_gain_q;
        end else if (go_up_s) begin
            cur_gain_d = up_gain_s;
            state_d    = settle(up_gain_s, eff_s, UP);
        end else if (go_down_s) begin
            cur_gain_d = down_gain_s;
            state_d    = settle(down_gain_s, eff_s, DOWN);
        end else begin
            cur_gain_d = cur_gain_q;
            state_d    = settle(cur_gain_q, eff_s, DOWN);
        end
    end

    // Output samples and clip flags capture the gain applied before this strobe's update
    always_comb begin
        out_left_d   = out_left_q;
        out_right_d  = out_right_q;
        clip_left_d  = clip_left_q;
        clip_right_d = clip_right_q;
        if (strobe_s) begin
            out_left_d   = mul_left_s;
            out_right_d  = mul_right_s;
            clip_left_d  = mul_clip_left_s;
            clip_right_d = mul_clip_right_s;
        end else begin
            out_left_d   = out_left_q;
            out_right_d  = out_right_q;
            clip_left_d  = clip_left_q;
            clip_right_d = clip_right_q;
        end
    end

    // State and output registers; reset leaves the gain at zero for a soft start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= MUTED;
            cur_gain_q   <= GAIN_ZERO;
            out_left_q   <= DATA_ZERO;
            out_right_q  <= DATA_ZERO;
            clip_left_q  <= 1'b0;
            clip_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_gain_q   <= cur_gain_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            clip_left_q  <= clip_left_d;
            clip_right_q <= clip_right_d;
        end
    end

    assign out_left   = out_left_q;
    assign out_right  = out_right_q;
    assign cur_gain   = cur_gain_q;
    assign clip_left  = clip_left_q;
    assign clip_right = clip_right_q;
    assign ramping    = (state_q == UP) || (state_q == DOWN);

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Scoreboard bench for audio_volume_ramp: a step-1 and a step-4 instance share
// strobes and samples; expected outputs come from a small reference model.
module tb_audio_volume_ramp;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic read_ready = 1'b0;
    logic write_ready = 1'b0;
    logic mute = 1'b0;
    logic mute4 = 1'b0;
    logic signed [23:0] in_left = 24'sd0;
    logic signed [23:0] in_right = 24'sd0;
    logic [7:0] target_gain = 8'd0;
    logic [7:0] target4 = 8'd0;

    logic signed [23:0] out_left, out_right, out_left4, out_right4;
    logic [7:0] cur_gain, cur_gain4;
    logic ramping, ramping4, clip_left, clip_right, clip_left4, clip_right4;

    typedef struct {
        int   l;
        int   r;
        logic cl;
        logic cr;
        int   g;
        logic rp;
        int   g4;
        logic rp4;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int m_gain = 0;
    int m_gain4 = 0;
    int last_l = 0;
    int last_r = 0;

    always #5 clk = ~clk;

    audio_volume_ramp #(.DATA_WIDTH(24), .GAIN_WIDTH(8), .RAMP_STEP(1)) dut (
        .clk(clk), .reset(reset), .read_ready(read_ready), .write_ready(write_ready),
        .in_left(in_left), .in_right(in_right), .target_gain(target_gain), .mute(mute),
        .out_left(out_left), .out_right(out_right), .cur_gain(cur_gain), .ramping(ramping),
        .clip_left(clip_left), .clip_right(clip_right)
    );

    audio_volume_ramp #(.DATA_WIDTH(24), .GAIN_WIDTH(8), .RAMP_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .read_ready(read_ready), .write_ready(write_ready),
        .in_left(in_left), .in_right(in_right), .target_gain(target4), .mute(mute4),
        .out_left(out_left4), .out_right(out_right4), .cur_gain(cur_gain4), .ramping(ramping4),
        .clip_left(clip_left4), .clip_right(clip_right4)
    );

    function automatic longint scaled(input int x, input int g);
        longint p;
        p = longint'(x) * longint'(g);
        return p >>> 7;
    endfunction

    function automatic int sat_val(input int x, input int g);
        longint q;
        q = scaled(x, g);
        if (q > 64'sd8388607) return 8388607;
        if (q < -64'sd8388608) return -8388608;
        return int'(q);
    endfunction

    function automatic logic sat_clip(input int x, input int g);
        longint q;
        q = scaled(x, g);
        return (q > 64'sd8388607) || (q < -64'sd8388608);
    endfunction

    function automatic int model_step(input int g, input int eff, input int st);
        if (eff > g) return ((eff - g) <= st) ? eff : g + st;
        if (eff < g) return ((g - eff) <= st) ? eff : g - st;
        return g;
    endfunction

    // One sample strobe: push the model's prediction, then pop and compare after the edge
    task automatic drive_strobe(input int l, input int r, input string tag);
        exp_t e;
        int eff;
        int eff4;
        @(negedge clk);
        in_left = l;
        in_right = r;
        read_ready = 1'b1;
        write_ready = 1'b1;
        eff  = mute  ? 0 : int'(target_gain);
        eff4 = mute4 ? 0 : int'(target4);
        e.l  = sat_val(l, m_gain);
        e.r  = sat_val(r, m_gain);
        e.cl = sat_clip(l, m_gain);
        e.cr = sat_clip(r, m_gain);
        m_gain  = model_step(m_gain, eff, 1);
        m_gain4 = model_step(m_gain4, eff4, 4);
        e.g   = m_gain;
        e.rp  = (m_gain != eff);
        e.g4  = m_gain4;
        e.rp4 = (m_gain4 != eff4);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++; if (out_left !== e.l) begin errors++; $display("FAIL %s out_left got %0d want %0d", tag, out_left, e.l); end
        checks++; if (out_right !== e.r) begin errors++; $display("FAIL %s out_right got %0d want %0d", tag, out_right, e.r); end
        checks++; if (clip_left !== e.cl) begin errors++; $display("FAIL %s clip_left got %b want %b", tag, clip_left, e.cl); end
        checks++; if (clip_right !== e.cr) begin errors++; $display("FAIL %s clip_right got %b want %b", tag, clip_right, e.cr); end
        checks++; if (cur_gain !== 8'(e.g)) begin errors++; $display("FAIL %s cur_gain got %0d want %0d", tag, cur_gain, e.g); end
        checks++; if (ramping !== e.rp) begin errors++; $display("FAIL %s ramping got %b want %b", tag, ramping, e.rp); end
        checks++; if (cur_gain4 !== 8'(e.g4)) begin errors++; $display("FAIL %s cur_gain4 got %0d want %0d", tag, cur_gain4, e.g4); end
        checks++; if (ramping4 !== e.rp4) begin errors++; $display("FAIL %s ramping4 got %b want %b", tag, ramping4, e.rp4); end
        last_l = e.l;
        last_r = e.r;
        read_ready = 1'b0;
        write_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        read_ready = 1'b0;
        write_ready = 1'b0;
        sb.delete();
        m_gain = 0;
        m_gain4 = 0;
        last_l = 0;
        last_r = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_left !== 24'sd0 || out_right !== 24'sd0) begin errors++; $display("FAIL reset_out got %0d/%0d want 0/0", out_left, out_right); end
        checks++; if (cur_gain !== 8'd0) begin errors++; $display("FAIL reset_gain got %0d want 0", cur_gain); end
        checks++; if (clip_left !== 1'b0 || clip_right !== 1'b0 || ramping !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", clip_left, clip_right, ramping); end
        apply_reset();
    endtask

    task automatic test_soft_start();
        target_gain = 8'd128;
        target4 = 8'd128;
        mute = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            drive_strobe(1000, -3, "soft_start");
            checks++; if (cur_gain !== 8'(i)) begin errors++; $display("FAIL soft_count got %0d want %0d", cur_gain, i); end
            if (i == 2) begin
                checks++; if (out_right !== -24'sd1) begin errors++; $display("FAIL floor got %0d want -1", out_right); end
            end
            if (i == 60) begin
                // Half strobes and idle clocks with changed inputs must not advance anything
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    in_left = 24'sd5000;
                    in_right = -24'sd5000;
                    read_ready = (k < 5);
                    write_ready = (k >= 5) && (k < 8);
                    @(posedge clk);
                    #1;
                    checks++; if (cur_gain !== 8'(m_gain) || out_left !== last_l || out_right !== last_r) begin
                        errors++; $display("FAIL stall got %0d/%0d/%0d want %0d/%0d/%0d", cur_gain, out_left, out_right, m_gain, last_l, last_r);
                    end
                end
                read_ready = 1'b0;
                write_ready = 1'b0;
            end
        end
        checks++; if (ramping !== 1'b0 || cur_gain !== 8'd128) begin errors++; $display("FAIL soft_idle got %0d ramp %b want 128 ramp 0", cur_gain, ramping); end
    endtask

    task automatic test_unity_floor();
        drive_strobe(1000, -3, "unity");
        checks++; if (out_left !== 24'sd1000 || out_right !== -24'sd3) begin errors++; $display("FAIL unity got %0d/%0d want 1000/-3", out_left, out_right); end
    endtask

    task automatic test_saturation();
        target_gain = 8'd255;
        for (int i = 0; i < 127; i++) drive_strobe(0, 0, "ramp_to_255");
        checks++; if (cur_gain !== 8'd255 || ramping !== 1'b0) begin errors++; $display("FAIL gain_top got %0d ramp %b want 255 ramp 0", cur_gain, ramping); end
        drive_strobe(6291456, -8388608, "saturate");
        checks++; if (out_left !== 24'sh7FFFFF || out_right !== 24'sh800000) begin errors++; $display("FAIL sat_val got %0d/%0d want 8388607/-8388608", out_left, out_right); end
        checks++; if (clip_left !== 1'b1 || clip_right !== 1'b1) begin errors++; $display("FAIL sat_clip got %b%b want 11", clip_left, clip_right); end
        drive_strobe(0, 0, "clip_clear");
        checks++; if (clip_left !== 1'b0 || clip_right !== 1'b0 || out_left !== 24'sd0) begin errors++; $display("FAIL clip_clear got %b%b out %0d want 00 out 0", clip_left, clip_right, out_left); end
    endtask

    task automatic test_target_change();
        checks++; if (cur_gain4 !== 8'd128 || ramping4 !== 1'b0) begin errors++; $display("FAIL step4_idle got %0d ramp %b want 128 ramp 0", cur_gain4, ramping4); end
        target4 = 8'd100;
        for (int k = 1; k <= 7; k++) begin
            drive_strobe(200, -200, "step4_down");
            checks++; if (cur_gain4 !== 8'(128 - 4 * k)) begin errors++; $display("FAIL step4_seq got %0d want %0d", cur_gain4, 128 - 4 * k); end
        end
        checks++; if (ramping4 !== 1'b0) begin errors++; $display("FAIL step4_settle got ramp %b want 0", ramping4); end
        target4 = 8'd98;
        drive_strobe(200, -200, "step4_clamp");
        checks++; if (cur_gain4 !== 8'd98 || ramping4 !== 1'b0) begin errors++; $display("FAIL step4_clamp got %0d ramp %b want 98 ramp 0", cur_gain4, ramping4); end
    endtask

    task automatic test_mute_mid_ramp();
        apply_reset();
        target_gain = 8'd128;
        mute = 1'b0;
        for (int i = 0; i < 60; i++) drive_strobe(2000, -2000, "ramp_to_60");
        checks++; if (cur_gain !== 8'd60 || ramping !== 1'b1) begin errors++; $display("FAIL at60 got %0d ramp %b want 60 ramp 1", cur_gain, ramping); end
        mute = 1'b1;
        drive_strobe(2000, -2000, "mute_first");
        checks++; if (cur_gain !== 8'd59) begin errors++; $display("FAIL mute_first got %0d want 59", cur_gain); end
        for (int i = 0; i < 29; i++) drive_strobe(2000, -2000, "mute_down");
        mute = 1'b0;
        drive_strobe(2000, -2000, "unmute");
        checks++; if (cur_gain !== 8'd31 || ramping !== 1'b1) begin errors++; $display("FAIL unmute got %0d ramp %b want 31 ramp 1", cur_gain, ramping); end
        for (int i = 0; i < 9; i++) drive_strobe(2000, -2000, "unmute_up");
        mute = 1'b1;
        for (int i = 0; i < 40; i++) drive_strobe(2000, -2000, "mute_to_zero");
        checks++; if (cur_gain !== 8'd0 || ramping !== 1'b0) begin errors++; $display("FAIL muted got %0d ramp %b want 0 ramp 0", cur_gain, ramping); end
        drive_strobe(2000, -2000, "muted_hold");
        checks++; if (out_left !== 24'sd0 || ramping !== 1'b0) begin errors++; $display("FAIL muted_hold got %0d ramp %b want 0 ramp 0", out_left, ramping); end
        mute = 1'b0;
    endtask

    task automatic test_async_reset();
        target_gain = 8'd128;
        for (int i = 0; i < 20; i++) drive_strobe(3000, 4000, "pre_reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (out_left !== 24'sd0 || out_right !== 24'sd0) begin errors++; $display("FAIL async_out got %0d/%0d want 0/0", out_left, out_right); end
        checks++; if (cur_gain !== 8'd0 || cur_gain4 !== 8'd0) begin errors++; $display("FAIL async_gain got %0d/%0d want 0/0", cur_gain, cur_gain4); end
        checks++; if (ramping !== 1'b0 || clip_left !== 1'b0 || clip_right !== 1'b0) begin errors++; $display("FAIL async_flags got %b%b%b want 000", ramping, clip_left, clip_right); end
        apply_reset();
        for (int i = 0; i < 3; i++) drive_strobe(3000, 4000, "restart");
        checks++; if (cur_gain !== 8'd3) begin errors++; $display("FAIL restart got %0d want 3", cur_gain); end
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_unity_floor();
        test_saturation();
        test_target_change();
        test_mute_mid_ramp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
